wb_burst_responder: RTL and testbench
=====================================

Name: wb_burst_responder

Overview:
- Wishbone responder (slave) for the 16-bit inner bus: the far end of the cache-side initiators (icache/dcache) that issue single, 4-beat and 8-beat burst cycles.
- Backs the bus with an internal word-addressed register-array memory.
- Used as an on-die scratch/boot RAM target and as the bench responder for cache and interconnect verification.
- Supports byte selects, a programmable first-beat latency, and wrapping bursts.

Parameters:
- ADDR_W, 24, Wishbone word-address width.
- DEPTH_LOG2, 6, log2 of memory depth in 16-bit words; must be at least 3.
- WAIT_STATES, 1, idle cycles between request acceptance and the first ack (0..7).

Ports:
- i_clk  input  1  bus clock
- i_rst  input  1  synchronous reset, active-low
- wb_cyc  input  1  cycle valid
- wb_stb  input  1  strobe
- wb_we  input  1  write enable
- wb_adr  input  ADDR_W  word address, sampled at request acceptance
- wb_i_dat  input  16  write data
- wb_sel  input  2  byte selects; [1] = bits 15:8, [0] = bits 7:0
- wb_4_burst  input  1  4-beat wrapping burst request
- wb_8_burst  input  1  8-beat wrapping burst request (wins if both set)
- wb_o_dat  output  16  read data
- wb_ack  output  1  beat acknowledge
- wb_err  output  1  error terminate

Behaviour:
- Reset (i_rst low at a rising edge):
  - wb_ack=0, wb_err=0, wb_o_dat=0, FSM to IDLE, beat counter 0.
  - Memory contents are not cleared.
  - Reset asserted mid-burst aborts the burst; no further ack.
- Request = wb_cyc & wb_stb. Accepted only in IDLE. At acceptance, latch adr, we, and burst length (1, 4 or 8).
- FSM states:
  - IDLE: request -> WAIT when WAIT_STATES>0, else -> BEAT.
  - WAIT: count down WAIT_STATES cycles, then -> BEAT. Request drop -> IDLE with no ack.
  - BEAT: wb_ack=1 for exactly one cycle per beat; beats issue back-to-back on consecutive cycles.
    - Last beat -> DONE.
    - Request drop while in BEAT -> IDLE immediately; ack is deasserted the same cycle it is sampled.
  - DONE: one-cycle turnaround with ack=0 -> IDLE. A new request can therefore be accepted at the earliest 2 cycles after the last ack.
- Latency: first ack appears 1+WAIT_STATES cycles after the accepted request edge. With WAIT_STATES=0, ack is registered in the cycle after acceptance.
- Burst addressing:
  - Beat n address = {base[ADDR_W-1:k], (base[k-1:0]+n) mod 2^k}, with k=2 (4-beat) or k=3 (8-beat).
  - This is a wrapping burst inside the aligned block; the critical word is returned first.
  - The master presents the address once; wb_adr is ignored after acceptance.
- Reads: wb_o_dat holds mem[beat address] in the same cycle as wb_ack. When ack=0, wb_o_dat holds its last value.
- Writes:
  - wb_i_dat is sampled on each ack cycle.
  - Each byte lane is written only if its wb_sel bit is set; sel=00 acks with no write.
  - Sel is sampled per beat.
- Memory index = beat address[DEPTH_LOG2-1:0].
- wb_ack and wb_err are never high in the same cycle.

Optional Feature:
- Macro WB_RESP_RANGE_ERR_EN.
- Defined:
  - An accepted request whose base address has any bit at or above DEPTH_LOG2 set gets a single wb_err pulse in place of the first ack. Timing is the same as the first ack.
  - The whole burst is terminated: no memory write, no further beats, then DONE -> IDLE.
  - wb_o_dat is unchanged.
- Undefined: wb_err is tied 0 and upper address bits alias, i.e. addresses wrap modulo 2^DEPTH_LOG2.

Test Plan:
- Single write then read, WAIT_STATES=1:
  - Write adr 0x000005, dat 0xBEEF, sel 11 -> ack 2 cycles after the request.
  - Read of adr 0x000005 -> 0xBEEF.
- Byte lanes:
  - Write 0x1234 sel 11, then 0xAB00 sel 10, then 0x00CD sel 01 to adr 3 -> read returns 0xABCD.
- 4-beat wrapping read:
  - Preload words 8..11 with 0x0008..0x000B; burst at base adr 10.
  - Response: 4 consecutive acks with data 0x000A, 0x000B, 0x0008, 0x0009, then 1 idle cycle.
- 8-beat write with stb dropped after beat 3:
  - Exactly 3 acks; only words base..base+2 are modified.
  - FSM back in IDLE; the next single read completes normally.
- Reset mid-burst:
  - i_rst low during beat 2 of a 4-beat read -> ack=0 the next cycle, no further acks.
  - After release, a fresh read returns the pre-reset memory contents.
- WB_RESP_RANGE_ERR_EN, DEPTH_LOG2=6:
  - Read at adr 0x000040 -> single err pulse, no ack; memory unchanged.
  - Without the macro, the same read returns mem[0].

Source files
------------

// File: rtl/wb_burst_responder_if.sv
// 16-bit inner-bus Wishbone bundle between cache initiators and
// wb_burst_responder, with burst-length hints.
interface wb_burst_responder_if #(
    parameter int ADDR_W = 24
);
    logic              wb_cyc;
    logic              wb_stb;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_adr;
    logic [15:0]       wb_i_dat;
    logic [1:0]        wb_sel;
    logic              wb_4_burst;
    logic              wb_8_burst;
    logic [15:0]       wb_o_dat;
    logic              wb_ack;
    logic              wb_err;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_i_dat,
        output wb_sel, wb_4_burst, wb_8_burst,
        input  wb_o_dat, wb_ack, wb_err
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_i_dat,
        input  wb_sel, wb_4_burst, wb_8_burst,
        output wb_o_dat, wb_ack, wb_err
    );
endinterface

// File: rtl/wb_burst_responder.sv
// Wishbone burst responder backed by a word-addressed register array.
// Define WB_RESP_RANGE_ERR_EN to error out-of-range base addresses.
module wb_burst_responder #(
    parameter int ADDR_W      = 24,
    parameter int DEPTH_LOG2  = 6,
    parameter int WAIT_STATES = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    wb_burst_responder_if.slave wb
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_BEAT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] WS_M1 =
        (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    logic [15:0]       r_mem [DEPTH];
    logic [1:0]        r_state;
    logic [2:0]        r_cnt;
    logic [2:0]        r_beat;
    logic [2:0]        r_mask;
    logic [ADDR_W-1:0] r_adr;
    logic              r_we;
    logic              r_ack;
    logic              r_err;
    logic [15:0]       r_dat;
    logic [15:0]       r_last;

    logic              w_req;
    logic              w_ack;
    logic              w_first;
    logic              w_wr;
    logic              w_range;
    logic              w_unused;
    logic [2:0]        w_mask_in;
    logic [15:0]       w_o_dat;
    logic [ADDR_W-1:0] w_first_adr;
    logic [ADDR_W-1:0] w_cur_adr;
    logic [ADDR_W-1:0] w_nxt_adr;

    // Wrap the beat offset inside the aligned block selected by mask.
    function automatic logic [ADDR_W-1:0] f_beat_adr(
        input logic [ADDR_W-1:0] base,
        input logic [2:0]        mask,
        input logic [2:0]        beat
    );
        logic [2:0] low;
        low = (base[2:0] & ~mask) | ((base[2:0] + beat) & mask);
        return {base[ADDR_W-1:3], low};
    endfunction

    assign w_req     = wb.wb_cyc & wb.wb_stb;
    assign w_mask_in = wb.wb_8_burst ? 3'd7 :
                       wb.wb_4_burst ? 3'd3 : 3'd0;

    assign w_first = ((r_state == S_IDLE) && w_req && (WAIT_STATES == 0))
                  || ((r_state == S_WAIT) && w_req && (r_cnt == 3'd0));

    assign w_first_adr = (r_state == S_IDLE) ? wb.wb_adr : r_adr;
    assign w_cur_adr   = f_beat_adr(r_adr, r_mask, r_beat);
    assign w_nxt_adr   = f_beat_adr(r_adr, r_mask, r_beat + 3'd1);

    assign w_wr = i_rst & (r_state == S_BEAT) & r_ack & w_req & r_we;

    // Gating by the live request lets a master drop stb mid-burst
    // without seeing a stray ack for the beat already queued.
    assign w_ack   = r_ack & w_req;
    assign w_o_dat = w_ack ? r_dat : r_last;

    assign wb.wb_ack   = w_ack;
    assign wb.wb_o_dat = w_o_dat;

`ifdef WB_RESP_RANGE_ERR_EN
    assign w_range   = |w_first_adr[ADDR_W-1:DEPTH_LOG2];
    assign wb.wb_err = r_err & w_req;
    assign w_unused  = ^{w_cur_adr[ADDR_W-1:DEPTH_LOG2],
                         w_nxt_adr[ADDR_W-1:DEPTH_LOG2]};
`else
    assign w_range   = 1'b0;
    assign wb.wb_err = 1'b0;
    assign w_unused  = ^{w_first_adr[ADDR_W-1:DEPTH_LOG2],
                         w_cur_adr[ADDR_W-1:DEPTH_LOG2],
                         w_nxt_adr[ADDR_W-1:DEPTH_LOG2], r_err};
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_beat  <= 3'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= 16'h0000;
            r_last  <= 16'h0000;
        end else begin
            r_last <= w_o_dat;
            unique case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_adr   <= wb.wb_adr;
                        r_we    <= wb.wb_we;
                        r_mask  <= w_mask_in;
                        r_cnt   <= WS_M1;
                        r_state <= (WAIT_STATES == 0) ? S_BEAT : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!w_req) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 3'd0) begin
                        r_state <= S_BEAT;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_BEAT: begin
                    if (!w_req || r_err || (r_beat == r_mask)) begin
                        r_ack   <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= w_req ? S_DONE : S_IDLE;
                    end else begin
                        r_beat <= r_beat + 3'd1;
                        r_dat  <= r_mem[w_nxt_adr[DEPTH_LOG2-1:0]];
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_first) begin
                r_beat <= 3'd0;
                if (w_range) begin
                    r_err <= 1'b1;
                end else begin
                    r_ack <= 1'b1;
                    r_dat <= r_mem[w_first_adr[DEPTH_LOG2-1:0]];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            if (wb.wb_sel[1]) begin
                r_mem[w_cur_adr[DEPTH_LOG2-1:0]][15:8] <= wb.wb_i_dat[15:8];
            end
            if (wb.wb_sel[0]) begin
                r_mem[w_cur_adr[DEPTH_LOG2-1:0]][7:0] <= wb.wb_i_dat[7:0];
            end
        end
    end
endmodule

// File: tb/tb_wb_burst_responder.sv
// Randomised scoreboard bench for wb_burst_responder; the expected
// response for WB_RESP_RANGE_ERR_EN follows the same macro.
module tb_wb_burst_responder;
    localparam int WS = 1;
    localparam int DL = 6;
    localparam int NW = 1 << DL;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    wb_burst_responder_if #(.ADDR_W(24)) bus ();

    wb_burst_responder #(
        .ADDR_W      (24),
        .DEPTH_LOG2  (DL),
        .WAIT_STATES (WS)
    ) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .wb    (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic        rd;
        logic [15:0] dat;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] ref_mem [NW];
    logic [15:0] drv_dat [8];
    logic [1:0]  drv_sel [8];
    int          vectors     = 0;
    int          miscompares = 0;

    always @(negedge clk) begin
        exp_t e;
        if (bus.wb_ack || bus.wb_err) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_resp ack=%0b err=%0b required no response",
                         bus.wb_ack, bus.wb_err);
            end else begin
                e = sb.pop_front();
                if (bus.wb_err !== e.err || bus.wb_ack !== !e.err ||
                    (e.rd && bus.wb_o_dat !== e.dat)) begin
                    miscompares++;
                    $display("FAIL beat got ack=%0b err=%0b dat=%h required ack=%0b err=%0b dat=%h",
                             bus.wb_ack, bus.wb_err, bus.wb_o_dat, !e.err, e.err, e.dat);
                end
            end
        end
    end

    task automatic put_beat(input int i);
        bus.wb_i_dat = drv_dat[i];
        bus.wb_sel   = drv_sel[i];
    endtask

    task automatic set_beat(input int i, input logic [15:0] d, input logic [1:0] s);
        drv_dat[i] = d;
        drv_sel[i] = s;
    endtask

    // One master cycle: model the expected beats, then drive and time them.
    task automatic run(input logic [23:0] adr, input logic we, input int blen,
                       input int stop, input bit rst_mid);
        int n_exp, got, cyc, first, last;
        bit err;
        err = 1'b0;
`ifdef WB_RESP_RANGE_ERR_EN
        err = (adr >= 24'(NW));
`endif
        if (err) begin
            sb.push_back('{err: 1'b1, rd: 1'b0, dat: 16'h0});
            n_exp = 1;
        end else begin
            n_exp = stop;
            for (int n = 0; n < stop; n++) begin
                int a;
                a = ((int'(adr) / blen) * blen + (int'(adr) + n) % blen) % NW;
                if (we) begin
                    if (drv_sel[n][1]) ref_mem[a][15:8] = drv_dat[n][15:8];
                    if (drv_sel[n][0]) ref_mem[a][7:0]  = drv_dat[n][7:0];
                    sb.push_back('{err: 1'b0, rd: 1'b0, dat: 16'h0});
                end else begin
                    sb.push_back('{err: 1'b0, rd: 1'b1, dat: ref_mem[a]});
                end
            end
        end

        bus.wb_adr     = adr;
        bus.wb_we      = we;
        bus.wb_4_burst = (blen == 4);
        bus.wb_8_burst = (blen == 8);
        put_beat(0);
        bus.wb_cyc = 1'b1;
        bus.wb_stb = 1'b1;
        got = 0; cyc = 0; first = -1; last = -1;
        while (got < n_exp && cyc < 40) begin
            @(negedge clk);
            if (bus.wb_ack || bus.wb_err) begin
                if (first < 0) first = cyc;
                last = cyc;
                got++;
                if (rst_mid && got == n_exp) rst_n = 1'b0;
            end
            @(posedge clk);
            #1;
            if (got < 8) put_beat(got);
            bus.wb_adr = 24'($urandom);
            cyc++;
        end

        vectors++;
        if (got != n_exp) begin
            miscompares++;
            $display("FAIL resp_count adr=%h got=%0d required=%0d", adr, got, n_exp);
        end else begin
            vectors++;
            if (first != 1 + WS || last != first + n_exp - 1) begin
                miscompares++;
                $display("FAIL timing adr=%h first=%0d last=%0d required first=%0d last=%0d",
                         adr, first, last, 1 + WS, WS + n_exp);
            end
        end

        if (rst_mid) begin
            repeat (2) begin
                @(negedge clk);
                vectors++;
                if (bus.wb_ack !== 1'b0 || bus.wb_o_dat !== 16'h0) begin
                    miscompares++;
                    $display("FAIL rst_abort ack=%0b dat=%h required ack=0 dat=0000",
                             bus.wb_ack, bus.wb_o_dat);
                end
            end
            @(posedge clk);
            #1;
        end
        bus.wb_cyc     = 1'b0;
        bus.wb_stb     = 1'b0;
        bus.wb_4_burst = 1'b0;
        bus.wb_8_burst = 1'b0;
        if (rst_mid) begin
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.wb_cyc = 0; bus.wb_stb = 0; bus.wb_we = 0;
        bus.wb_adr = 0; bus.wb_i_dat = 0; bus.wb_sel = 0;
        bus.wb_4_burst = 0; bus.wb_8_burst = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.wb_ack !== 1'b0) begin
            miscompares++; $display("FAIL reset_ack got=%0b required=0", bus.wb_ack);
        end
        vectors++;
        if (bus.wb_err !== 1'b0) begin
            miscompares++; $display("FAIL reset_err got=%0b required=0", bus.wb_err);
        end
        vectors++;
        if (bus.wb_o_dat !== 16'h0) begin
            miscompares++; $display("FAIL reset_dat got=%h required=0000", bus.wb_o_dat);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NW; i++) begin
            set_beat(0, 16'($urandom), 2'b11);
            run(24'(i), 1'b1, 1, 1, 1'b0);
        end

        set_beat(0, 16'hBEEF, 2'b11);
        run(24'h5, 1'b1, 1, 1, 1'b0);
        run(24'h5, 1'b0, 1, 1, 1'b0);

        set_beat(0, 16'h1234, 2'b11); run(24'h3, 1'b1, 1, 1, 1'b0);
        set_beat(0, 16'hAB00, 2'b10); run(24'h3, 1'b1, 1, 1, 1'b0);
        set_beat(0, 16'h00CD, 2'b01); run(24'h3, 1'b1, 1, 1, 1'b0);
        run(24'h3, 1'b0, 1, 1, 1'b0);

        for (int i = 8; i < 12; i++) begin
            set_beat(0, 16'(i), 2'b11);
            run(24'(i), 1'b1, 1, 1, 1'b0);
        end
        run(24'hA, 1'b0, 4, 4, 1'b0);
        run(24'h2D, 1'b0, 8, 8, 1'b0);

        for (int i = 0; i < 8; i++) set_beat(i, 16'($urandom), 2'b11);
        run(24'h18, 1'b1, 8, 3, 1'b0);
        for (int i = 24; i < 32; i++) run(24'(i), 1'b0, 1, 1, 1'b0);

        run(24'h20, 1'b0, 4, 2, 1'b1);
        run(24'h20, 1'b0, 4, 4, 1'b0);

        run(24'h40, 1'b0, 1, 1, 1'b0);
        set_beat(0, 16'h5A5A, 2'b11);
        run(24'h41, 1'b1, 1, 1, 1'b0);
        run(24'h1, 1'b0, 1, 1, 1'b0);
        run(24'h40, 1'b0, 1, 1, 1'b0);

        for (int t = 0; t < 200; t++) begin
            int          blen, stop;
            logic [23:0] adr;
            logic        we;
            blen = ($urandom_range(0, 2) == 0) ? 1 :
                   ($urandom_range(0, 1) == 0) ? 4 : 8;
            adr  = ($urandom_range(0, 7) == 0) ? 24'($urandom)
                                                : 24'($urandom_range(0, NW - 1));
            we   = 1'($urandom);
            stop = blen;
            if (blen > 1 && $urandom_range(0, 5) == 0) stop = $urandom_range(1, blen - 1);
            for (int i = 0; i < 8; i++) set_beat(i, 16'($urandom), 2'($urandom));
            run(adr, we, blen, stop, 1'b0);
        end

        repeat (3) @(posedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_expected got=%0d required=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout required=completion");
        $fatal(1, "bench timeout");
    end
endmodule
